data_mem_responder: RTL and testbench

- Memory-side responder for the processor data-memory port: the slave end of the load/store interface that the core drives with address, write data and write enable.
- Replaces the zero-latency RAM with a handshaked, multi-cycle responder that supports configurable wait states and returns an error response for illegal accesses.
- Sits between the core (or a future bus/cache stage) and the data storage. Exports the 16-bit test_value observation word to the board.

---
 rtl/data_mem_responder_if.sv | 30 +++
 rtl/data_mem_responder.sv | 134 +++++++++++++
 tb/tb_data_mem_responder.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Load/store handshake bundle between the core (master) and the data-memory
// responder (slave).
//   req_valid/req_ready  : request handshake, core -> memory
//   req_we               : 1 = store, 0 = load
//   req_addr/req_wdata   : byte address and store data
//   resp_valid/resp_ready: response handshake, memory -> core
//   resp_rdata/resp_err  : load data (0 for stores/errors) and error flag
interface data_mem_responder_if #(
    parameter int unsigned Size = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [Size-1:0] req_addr;
    logic [Size-1:0] req_wdata;
    logic            resp_valid;
    logic            resp_ready;
    logic [Size-1:0] resp_rdata;
    logic            resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Handshaked, multi-cycle data-memory responder with configurable wait states
// and an error response for misaligned or out-of-range accesses.
//   CLK        : clock, rising edge
//   Reset      : synchronous active-high reset; clears FSM, latches and storage
//   bus        : slave end of the load/store request/response handshake
//   test_value : low 16 bits of the storage word at TEST_ADDR
module data_mem_responder #(
    parameter int unsigned Size        = 32,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_STATES = 2,
    parameter int unsigned TEST_ADDR   = 0
) (
    input  logic                 CLK,
    input  logic                 Reset,
    data_mem_responder_if.slave  bus,
    output logic [15:0]          test_value
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] TEST_IDX = AW'(TEST_ADDR / 4);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t          state, state_n;
    logic [3:0]      cnt, cnt_n;
    logic            lat_we;
    logic [Size-1:0] lat_addr;
    logic [Size-1:0] lat_wdata;
    logic [Size-1:0] mem [DEPTH];
    logic [Size-1:0] rdata_q;
    logic            err_q;

    logic            accept, commit, handshake;
    logic            req_ready_c, resp_valid_c;
    logic            cur_we;
    logic [Size-1:0] cur_addr, cur_wdata;
    logic            cur_legal;
    logic [AW-1:0]   cur_idx;

    // With zero wait states the commit edge is the accept edge, so the request
    // must come straight from the bus rather than from the latch.
    always_comb begin
        cur_we    = lat_we;
        cur_addr  = lat_addr;
        cur_wdata = lat_wdata;
        if (state == S_IDLE) begin
            cur_we    = bus.req_we;
            cur_addr  = bus.req_addr;
            cur_wdata = bus.req_wdata;
        end
    end

    assign cur_legal = (cur_addr[1:0] == 2'b00) && (cur_addr[Size-1:AW+2] == '0);
    assign cur_idx   = cur_addr[AW+1:2];

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        req_ready_c  = 1'b0;
        resp_valid_c = 1'b0;
        accept       = 1'b0;
        commit       = 1'b0;
        handshake    = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready_c = 1'b1;
                if (bus.req_valid) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_n = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_n = S_WAIT;
                        cnt_n   = 4'(WAIT_STATES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    state_n = S_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            S_RESP: begin
                resp_valid_c = 1'b1;
                if (bus.resp_ready) begin
                    handshake = 1'b1;
                    state_n   = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                lat_we    <= bus.req_we;
                lat_addr  <= bus.req_addr;
                lat_wdata <= bus.req_wdata;
            end
            if (commit) begin
                err_q   <= ~cur_legal;
                rdata_q <= (cur_legal && !cur_we) ? mem[cur_idx] : '0;
                if (cur_legal && cur_we) begin
                    mem[cur_idx] <= cur_wdata;
                end
            end else if (handshake) begin
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.resp_valid = resp_valid_c;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign test_value     = mem[TEST_IDX][15:0];
endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
    logic CLK = 1'b0;
    logic Reset;
    always #5 CLK = ~CLK;

    data_mem_responder_if #(.Size(32)) a_if ();
    data_mem_responder_if #(.Size(32)) b_if ();
    logic [15:0] tv_a, tv_b;

    data_mem_responder #(.Size(32), .DEPTH(64), .WAIT_STATES(2), .TEST_ADDR(0)) dut_a (
        .CLK(CLK), .Reset(Reset), .bus(a_if.slave), .test_value(tv_a)
    );
    data_mem_responder #(.Size(32), .DEPTH(64), .WAIT_STATES(0), .TEST_ADDR(0)) dut_b (
        .CLK(CLK), .Reset(Reset), .bus(b_if.slave), .test_value(tv_b)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [31:0] model_a [64];
    logic [31:0] model_b [64];
    int          vectors = 0;
    int          errors  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? b_if.req_ready : a_if.req_ready;
    endfunction

    function automatic logic rv(input bit sel);
        return sel ? b_if.resp_valid : a_if.resp_valid;
    endfunction

    task automatic set_req(input bit sel, input logic v, input logic we,
                           input logic [31:0] addr, input logic [31:0] wd);
        if (sel) begin
            b_if.req_valid = v; b_if.req_we = we; b_if.req_addr = addr; b_if.req_wdata = wd;
        end else begin
            a_if.req_valid = v; a_if.req_we = we; a_if.req_addr = addr; a_if.req_wdata = wd;
        end
    endtask

    task automatic clear_models();
        for (int i = 0; i < 64; i++) begin
            model_a[i] = '0;
            model_b[i] = '0;
        end
        q_a.delete();
        q_b.delete();
    endtask

    // Reference model: decides legality, applies stores, queues expected response.
    task automatic expect_txn(input bit sel, input logic we, input logic [31:0] addr,
                              input logic [31:0] wd);
        exp_t        e;
        logic        legal;
        int unsigned idx;
        legal   = (addr[1:0] == 2'b00) && (addr[31:2] < 30'd64);
        idx     = int'(addr[7:2]);
        e.err   = !legal;
        e.rdata = '0;
        if (legal) begin
            if (sel) begin
                if (we) model_b[idx] = wd; else e.rdata = model_b[idx];
            end else begin
                if (we) model_a[idx] = wd; else e.rdata = model_a[idx];
            end
        end
        if (sel) q_b.push_back(e); else q_a.push_back(e);
    endtask

    // Response monitors: pop the scoreboard on each response handshake.
    always @(negedge CLK) begin
        exp_t e;
        if (!Reset && a_if.resp_valid && a_if.resp_ready) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_resp", 32'(q_a.size()), 32'd1);
            end else begin
                e = q_a.pop_front();
                check("a_rdata", a_if.resp_rdata, e.rdata);
                check("a_err", {31'b0, a_if.resp_err}, {31'b0, e.err});
            end
        end
    end

    always @(negedge CLK) begin
        exp_t e;
        if (!Reset && b_if.resp_valid && b_if.resp_ready) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_resp", 32'(q_b.size()), 32'd1);
            end else begin
                e = q_b.pop_front();
                check("b_rdata", b_if.resp_rdata, e.rdata);
                check("b_err", {31'b0, b_if.resp_err}, {31'b0, e.err});
            end
        end
    end

    // Present a request, wait (bounded) for acceptance, leave the accept edge behind.
    task automatic send(input bit sel, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd);
        int k;
        set_req(sel, 1'b1, we, addr, wd);
        k = 0;
        while (!rdy(sel) && k < 50) begin
            tick();
            k++;
        end
        if (!rdy(sel)) check("accept_timeout", {31'b0, rdy(sel)}, 32'd1);
        expect_txn(sel, we, addr, wd);
        tick();
        set_req(sel, 1'b0, 1'b0, '0, '0);
    endtask

    // Called one cycle after the accept edge; counts cycles until resp_valid.
    task automatic wait_resp(input bit sel, input int exp_lat);
        int  n;
        bit  rr;
        n = 1;
        while (!rv(sel) && n < 40) begin
            tick();
            n++;
        end
        check(sel ? "b_latency" : "a_latency", 32'(n), 32'(exp_lat));
        if (!sel) check("a_test_value", {16'b0, tv_a}, {16'b0, model_a[0][15:0]});
        rr = sel ? b_if.resp_ready : a_if.resp_ready;
        if (rr) begin
            tick();
            check(sel ? "b_idle_ready" : "a_idle_ready", {31'b0, rdy(sel)}, 32'd1);
            check(sel ? "b_idle_valid" : "a_idle_valid", {31'b0, rv(sel)}, 32'd0);
        end
    endtask

    task automatic txn(input bit sel, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd);
        send(sel, we, addr, wd);
        wait_resp(sel, sel ? 1 : 3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   k;
        clear_models();
        Reset = 1'b1;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        a_if.resp_ready = 1'b1;
        b_if.resp_ready = 1'b1;
        tick(); tick(); tick();
        Reset = 1'b0;

        check("rst_req_ready", {31'b0, a_if.req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, a_if.resp_valid}, 32'd0);
        check("rst_rdata", a_if.resp_rdata, 32'd0);
        check("rst_err", {31'b0, a_if.resp_err}, 32'd0);
        check("rst_test_value", {16'b0, tv_a}, 32'd0);

        // Basic store, read-after-write, unwritten word.
        txn(0, 1'b1, 32'h0000_0000, 32'h0000_ABCD);
        txn(0, 1'b1, 32'h0000_0010, 32'h1234_5678);
        txn(0, 1'b0, 32'h0000_0010, 32'h0);
        txn(0, 1'b0, 32'h0000_0014, 32'h0);

        // Illegal accesses, then confirm storage untouched.
        txn(0, 1'b0, 32'h0000_0102, 32'h0);
        txn(0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
        txn(0, 1'b1, 32'h8000_0000, 32'h0BAD_0BAD);
        txn(0, 1'b1, 32'h0000_0001, 32'hFFFF_FFFF);
        txn(0, 1'b0, 32'h0000_0000, 32'h0);
        txn(0, 1'b0, 32'h0000_00FC, 32'h0);

        // Response back-pressure with a competing request held on the bus.
        a_if.resp_ready = 1'b0;
        send(0, 1'b0, 32'h0000_0010, 32'h0);
        k = 1;
        while (!a_if.resp_valid && k < 40) begin
            tick();
            k++;
        end
        check("stall_latency", 32'(k), 32'd3);
        set_req(0, 1'b1, 1'b1, 32'h0000_0020, 32'hCAFE_F00D);
        e = q_a[0];
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", {31'b0, a_if.resp_valid}, 32'd1);
            check("stall_req_ready", {31'b0, a_if.req_ready}, 32'd0);
            check("stall_rdata", a_if.resp_rdata, e.rdata);
            check("stall_err", {31'b0, a_if.resp_err}, {31'b0, e.err});
            tick();
        end
        a_if.resp_ready = 1'b1;
        tick();
        check("accept_after_hs", {31'b0, a_if.req_ready}, 32'd1);
        expect_txn(0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D);
        tick();
        set_req(0, 1'b0, 1'b0, '0, '0);
        check("accepted_busy", {31'b0, a_if.req_ready}, 32'd0);
        wait_resp(0, 3);
        txn(0, 1'b0, 32'h0000_0020, 32'h0);

        // Zero-wait-state instance.
        txn(1, 1'b1, 32'h0000_0008, 32'h0000_0011);
        txn(1, 1'b0, 32'h0000_0008, 32'h0);
        txn(1, 1'b0, 32'h0000_0004, 32'h0);
        txn(1, 1'b1, 32'h0000_0000, 32'h0000_7777);
        check("b_test_value", {16'b0, tv_b}, {16'b0, model_b[0][15:0]});
        txn(1, 1'b0, 32'h0000_0200, 32'h0);

        // Reset during WAIT aborts the store.
        check("abort_pre_ready", {31'b0, a_if.req_ready}, 32'd1);
        set_req(0, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_5555);
        tick();
        set_req(0, 1'b0, 1'b0, '0, '0);
        check("abort_in_wait", {31'b0, a_if.req_ready}, 32'd0);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        clear_models();
        check("abort_req_ready", {31'b0, a_if.req_ready}, 32'd1);
        check("abort_test_value", {16'b0, tv_a}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            check("abort_no_resp", {31'b0, a_if.resp_valid}, 32'd0);
            tick();
        end
        txn(0, 1'b0, 32'h0000_0000, 32'h0);
        check("abort_test_value_end", {16'b0, tv_a}, 32'd0);
        check("queue_a_drained", 32'(q_a.size()), 32'd0);
        check("queue_b_drained", 32'(q_b.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
